fifo_byte_packer: RTL and testbench
===================================

FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning bytes packed per output word (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning idle cycles before an auto-flush (legal 1..255, used only under REQ-024).
REQ-003 SHALL have port clk  input  1  the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port buf_out  input  8  byte from the upstream FIFO, valid one cycle after rd_en.
REQ-006 SHALL have port buf_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port rd_en  output  1  upstream FIFO read strobe.
REQ-008 SHALL have port flush  input  1  one-cycle request to emit a partial word.
REQ-009 SHALL have port m_data  output  8*LANES  packed word; first byte read is in bits [7:0].
REQ-010 SHALL have port m_keep  output  LANES  byte-valid mask, thermometer from bit 0.
REQ-011 SHALL have port m_valid  output  1  output word valid.
REQ-012 SHALL have port m_ready  input  1  downstream accept.

Function
REQ-013 SHALL implement states FILL and HOLD; reset state FILL.
REQ-014 SHALL, in FILL, drive rd_en = !buf_empty && (count + inflight) < LANES; rd_en SHALL never be high while buf_empty is high.
REQ-015 SHALL treat the upstream read latency as exactly 1 cycle: a byte requested in cycle N is captured from buf_out at the clock edge ending cycle N+1 into lane count, and count increments then.
REQ-016 SHALL move FILL->HOLD on the edge where count reaches LANES, with m_valid=1 and m_keep all ones from the next cycle.
REQ-017 SHALL hold m_data/m_keep stable while m_valid && !m_ready; rd_en SHALL be 0 in HOLD.
REQ-018 SHALL, on m_valid && m_ready, clear count, m_keep and m_data, deassert m_valid, and return to FILL; reads resume the following cycle.
REQ-019 SHALL, on flush in FILL with count>0, go to HOLD once inflight==0 with m_keep = (1<<count)-1; flush arriving while a read is in flight SHALL be latched and applied after the byte lands.
REQ-020 SHALL ignore flush when count==0 and inflight==0, and SHALL ignore flush in HOLD.
REQ-021 SHALL never lose or duplicate a byte under any pattern of buf_empty, m_ready and flush.

Reset
REQ-022 SHALL, while rst is low, force rd_en=0, m_valid=0, m_data=0, m_keep=0, count=0, inflight=0, pending flush=0 and state FILL, asynchronously, including mid-word; a byte in flight at reset SHALL be discarded.
REQ-023 SHALL release reset synchronously to clk, with no rd_en pulse in the first cycle after release.

Configuration
REQ-024 SHALL, with PACKER_TIMEOUT_EN defined, count consecutive FILL cycles with count>0, inflight==0 and buf_empty high, and raise an internal flush when the count reaches TIMEOUT; the counter SHALL clear on any byte capture or state change.
REQ-025 SHALL, without PACKER_TIMEOUT_EN, contain no timeout counter; partial words leave only via flush.

Structure
REQ-026 SHALL place the state encoding, the LANES/TIMEOUT defaults and the keep-mask width function in shared package fifo_pkg.
REQ-027 SHALL contain one sub-module, packer_timeout (the REQ-024 counter), instantiated only under PACKER_TIMEOUT_EN.

Verification
REQ-028 SHALL cover: FIFO preloaded with 0x01..0x08, m_ready=1 -> words 0x04030201 then 0x08070605, keep=0xF, no rd_en while buf_empty.
REQ-029 SHALL cover: 4 bytes 0x11..0x14, m_ready=0 for 10 cycles -> m_data=0x14131211 stable, rd_en=0 throughout, accepted on m_ready rise.
REQ-030 SHALL cover: 3 bytes 0xA1..0xA3 then flush -> m_data=0x00A3A2A1, m_keep=0x7; flush with empty packer -> no m_valid.
REQ-031 SHALL cover: flush in the same cycle as rd_en -> the in-flight byte is included (count 2 -> keep=0x7).
REQ-032 SHALL cover: rst low after 2 bytes captured -> all outputs 0 immediately; next 4 bytes form a fresh word from lane 0.
REQ-033 SHALL cover: PACKER_TIMEOUT_EN, TIMEOUT=16, 1 byte 0x5A then FIFO empty -> m_valid with m_keep=0x1 exactly 16 cycles after capture.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for fifo_byte_packer. Holds the packer
//               state encoding, the default LANES/TIMEOUT values and the
//               helper that sizes the lane counter, which also drives
//               keep-mask generation.
// Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

  // Two-state packer: collect bytes (FILL) or present a finished word (HOLD).
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

  localparam int c_lanes_default   = 4;
  localparam int c_timeout_default = 16;

  // Width of the lane counter. It must represent 0..lanes inclusive, because
  // the word is complete when the count equals lanes. The keep mask is the
  // thermometer (1 << count) - 1 of this count.
  function automatic int keep_cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/packer_timeout.sv
`default_nettype none
// ============================================================================
// Module      : packer_timeout
// Description : Idle counter for the byte packer. Counts consecutive cycles
//               in which i_active is high and fires o_fire in the cycle where
//               the count reaches TIMEOUT. Only built when PACKER_TIMEOUT_EN
//               is defined.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset
//               i_active - packer is idle with a partial word
//               i_clear  - byte captured or packer state changing
//               o_fire   - request an internal flush this cycle
// Revision    : 1.0  initial release
// ============================================================================
module packer_timeout
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_clear,
  output logic o_fire
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // The cycle that would bring the count to TIMEOUT is the firing cycle.
  assign o_fire = i_active && (cnt_q == 8'(TIMEOUT - 1));

  // Any break in the idle run restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_active) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_byte_packer
// Description : Reads bytes from an upstream FIFO (1-cycle read latency) and
//               packs LANES of them into one output word, first byte in the
//               low lane. A partial word leaves on flush with a thermometer
//               keep mask. Defining PACKER_TIMEOUT_EN adds an idle timeout
//               that raises an internal flush after TIMEOUT idle cycles.
// Ports       : clk       - clock
//               rst       - asynchronous active-low reset
//               buf_out   - upstream byte, valid the cycle after rd_en
//               buf_empty - upstream empty flag
//               rd_en     - upstream read strobe
//               flush     - one-cycle request to emit a partial word
//               m_data    - packed word (8*LANES bits)
//               m_keep    - byte-valid mask, thermometer from bit 0
//               m_valid   - output word valid
//               m_ready   - downstream accept
// Revision    : 1.0  initial release
// ============================================================================
module fifo_byte_packer
  import fifo_pkg::*;
#(
  parameter int LANES   = c_lanes_default,
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           buf_out,
  input  logic                 buf_empty,
  output logic                 rd_en,
  input  logic                 flush,
  output logic [8*LANES-1:0]   m_data,
  output logic [LANES-1:0]     m_keep,
  output logic                 m_valid,
  input  logic                 m_ready
);

  localparam int              c_cw        = keep_cnt_width(LANES);
  localparam logic [c_cw-1:0] c_lanes_val = c_cw'(LANES);

  // --------------------------------------------------------------------------
  // Reset: assertion is asynchronous; release is re-timed through two flops
  // so the core leaves reset on a clock edge and rd_en cannot pulse in the
  // cycles right after rst rises.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign w_rst_n = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // Packer state
  // --------------------------------------------------------------------------
  pack_state_e          state_q,      state_d;
  logic [c_cw-1:0]      count_q,      count_d;
  logic                 inflight_q,   inflight_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [8*LANES-1:0]   data_q,       data_d;
  logic [LANES-1:0]     keep_q,       keep_d;

  logic                 w_rd_en;
  logic                 w_flush_acc;
  logic                 w_flush_eff;
  logic                 w_timeout_flush;
  logic [c_cw-1:0]      w_occupancy;

  // Lanes already filled plus the one byte that may be on its way.
  assign w_occupancy = count_q + c_cw'(inflight_q);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    inflight_d   = 1'b0;
    flush_pend_d = flush_pend_q;
    data_d       = data_q;
    keep_d       = keep_q;
    w_rd_en      = 1'b0;
    w_flush_acc  = 1'b0;
    w_flush_eff  = 1'b0;

    case (state_q)
      ST_FILL: begin
        // A pending flush freezes reads so the word closes on the bytes
        // already requested.
        w_rd_en    = w_rst_n && !buf_empty && !flush_pend_q &&
                     (w_occupancy < c_lanes_val);
        inflight_d = w_rd_en;

        // Byte requested last cycle lands in the next free lane.
        if (inflight_q) begin
          for (int i = 0; i < LANES; i++) begin
            if (count_q == c_cw'(i)) begin
              data_d[8*i +: 8] = buf_out;
              keep_d[i]        = 1'b1;
            end
          end
          count_d = count_q + c_cw'(1);
        end

        // Flush only means something when a byte is held or on its way.
        w_flush_acc = (flush || w_timeout_flush) &&
                      ((count_q != '0) || inflight_q);
        w_flush_eff = flush_pend_q || w_flush_acc;

        if ((count_d == c_lanes_val) || (w_flush_eff && !w_rd_en)) begin
          state_d      = ST_HOLD;
          flush_pend_d = 1'b0;
        end else if (w_flush_eff) begin
          // A read issued this cycle must land before the word can close.
          flush_pend_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (m_ready) begin
          state_d      = ST_FILL;
          count_d      = '0;
          data_d       = '0;
          keep_d       = '0;
          flush_pend_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q      <= ST_FILL;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional idle timeout
  // --------------------------------------------------------------------------
`ifdef PACKER_TIMEOUT_EN
  logic w_to_active;
  logic w_to_clear;

  assign w_to_active = (state_q == ST_FILL) && (count_q != '0) &&
                       !inflight_q && buf_empty;
  assign w_to_clear  = inflight_q || (state_d != state_q);

  packer_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (w_rst_n),
    .i_active (w_to_active),
    .i_clear  (w_to_clear),
    .o_fire   (w_timeout_flush)
  );
`else
  // Partial words leave only through an external flush.
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT);
  assign w_timeout_flush  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_en   = w_rd_en;
  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_valid = (state_q == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_byte_packer
// Description : Directed self-checking bench for fifo_byte_packer (LANES=4,
//               TIMEOUT=16). A behavioural upstream FIFO answers rd_en with
//               one cycle of latency; each scenario task checks its own
//               hand-computed words. Build with PACKER_TIMEOUT_EN defined to
//               exercise the idle timeout instead of the no-timeout case.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  buf_out;
  logic        buf_empty;
  logic        rd_en;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;

  int checks   = 0;
  int failures = 0;

  fifo_byte_packer #(
    .LANES   (4),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buf_out   (buf_out),
    .buf_empty (buf_empty),
    .rd_en     (rd_en),
    .flush     (flush),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: push from tasks, pop on rd_en with 1-cycle latency.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int viol_empty = 0;
  int viol_hold  = 0;

  assign buf_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      buf_out <= mem[rd_ptr[5:0]];
      rd_ptr  <= rd_ptr + 1;
    end
    if (rd_en && buf_empty) viol_empty <= viol_empty + 1;
    if (rd_en && m_valid)   viol_hold  <= viol_hold + 1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Returns at the first negedge (including now) where m_valid is high.
  task automatic wait_valid(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (m_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (3) @(negedge clk);
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data: got %h expected 00000000", m_data); end
    checks++; if (m_keep !== 4'h0) begin failures++; $display("FAIL reset_m_keep: got %h expected 0", m_keep); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL release_rd_en: got %b expected 0", rd_en); end
  endtask

  task automatic test_stream();
    bit got;
    wait_valid(40, got);
    checks++; if (!got) begin failures++; $display("FAIL stream_w1_timeout: got no m_valid expected m_valid"); end
    checks++; if (m_data !== 32'h04030201) begin failures++; $display("FAIL stream_w1_data: got %h expected 04030201", m_data); end
    checks++; if (m_keep !== 4'hF) begin failures++; $display("FAIL stream_w1_keep: got %h expected f", m_keep); end
    @(negedge clk);
    wait_valid(40, got);
    checks++; if (!got) begin failures++; $display("FAIL stream_w2_timeout: got no m_valid expected m_valid"); end
    checks++; if (m_data !== 32'h08070605) begin failures++; $display("FAIL stream_w2_data: got %h expected 08070605", m_data); end
    checks++; if (m_keep !== 4'hF) begin failures++; $display("FAIL stream_w2_keep: got %h expected f", m_keep); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL stream_drained: got m_valid=%b expected 0", m_valid); end
    checks++; if (rd_ptr !== 8) begin failures++; $display("FAIL stream_reads: got %0d expected 8", rd_ptr); end
  endtask

  task automatic test_back_pressure();
    bit got;
    int bad_stable;
    int bad_rd;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
    wait_valid(40, got);
    checks++; if (!got) begin failures++; $display("FAIL bp_timeout: got no m_valid expected m_valid"); end
    checks++; if (m_data !== 32'h14131211) begin failures++; $display("FAIL bp_data: got %h expected 14131211", m_data); end
    bad_stable = 0;
    bad_rd     = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_data !== 32'h14131211 || m_keep !== 4'hF || m_valid !== 1'b1) bad_stable++;
      if (rd_en !== 1'b0) bad_rd++;
    end
    checks++; if (bad_stable !== 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad_stable); end
    checks++; if (bad_rd !== 0) begin failures++; $display("FAIL bp_rd_en: got %0d cycles with rd_en expected 0", bad_rd); end
    m_ready = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_accept: got m_valid=%b expected 0", m_valid); end
    // The fifth byte is read once the packer reopens; flush it out alone.
    repeat (4) @(negedge clk);
    pulse_flush();
    wait_valid(20, got);
    checks++; if (!got) begin failures++; $display("FAIL bp_tail_timeout: got no m_valid expected m_valid"); end
    checks++; if (m_data !== 32'h00000015 || m_keep !== 4'h1) begin failures++; $display("FAIL bp_tail: got %h/%h expected 00000015/1", m_data, m_keep); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit got;
    int seen;
    for (int i = 0; i < 3; i++) push(8'hA1 + 8'(i));
    repeat (6) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_early_valid: got %b expected 0", m_valid); end
    pulse_flush();
    wait_valid(20, got);
    checks++; if (!got) begin failures++; $display("FAIL flush_timeout: got no m_valid expected m_valid"); end
    checks++; if (m_data !== 32'h00A3A2A1) begin failures++; $display("FAIL flush_data: got %h expected 00a3a2a1", m_data); end
    checks++; if (m_keep !== 4'h7) begin failures++; $display("FAIL flush_keep: got %h expected 7", m_keep); end
    @(negedge clk);
    pulse_flush();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_empty: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_flush_inflight();
    bit got;
    push(8'hB1);
    push(8'hB2);
    repeat (6) @(negedge clk);
    push(8'hB3);
    flush = 1'b1;
    #1;
    checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL inflight_rd_en: got %b expected 1", rd_en); end
    @(negedge clk);
    flush = 1'b0;
    wait_valid(20, got);
    checks++; if (!got) begin failures++; $display("FAIL inflight_timeout: got no m_valid expected m_valid"); end
    checks++; if (m_data !== 32'h00B3B2B1) begin failures++; $display("FAIL inflight_data: got %h expected 00b3b2b1", m_data); end
    checks++; if (m_keep !== 4'h7) begin failures++; $display("FAIL inflight_keep: got %h expected 7", m_keep); end
    @(negedge clk);
  endtask

  task automatic test_reset_midword();
    bit got;
    push(8'hC1);
    push(8'hC2);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) push(8'hD1 + 8'(i));
    rst = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL midrst_rd_en: got %b expected 0", rd_en); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL midrst_data: got %h expected 00000000", m_data); end
    checks++; if (m_keep !== 4'h0 || m_valid !== 1'b0) begin failures++; $display("FAIL midrst_keep_valid: got %h/%b expected 0/0", m_keep, m_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_valid(40, got);
    checks++; if (!got) begin failures++; $display("FAIL midrst_timeout: got no m_valid expected m_valid"); end
    checks++; if (m_data !== 32'hD4D3D2D1) begin failures++; $display("FAIL midrst_data_after: got %h expected d4d3d2d1", m_data); end
    checks++; if (m_keep !== 4'hF) begin failures++; $display("FAIL midrst_keep_after: got %h expected f", m_keep); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit got;
    push(8'h5A);
    #1;
    checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL to_rd_en: got %b expected 1", rd_en); end
`ifdef PACKER_TIMEOUT_EN
    begin
      int first = 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (m_valid && first == 0) first = n;
      end
      // rd_en cycle N, capture at end of N+1, valid in cycle N+18.
      checks++; if (first !== 18) begin failures++; $display("FAIL to_latency: got %0d expected 18", first); end
    end
    // m_ready=1 so the word left one cycle after it appeared.
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL to_accepted: got m_valid=%b expected 0", m_valid); end
    checks++; if (rd_ptr !== wr_ptr) begin failures++; $display("FAIL to_reads: got %0d expected %0d", rd_ptr, wr_ptr); end
`else
    begin
      int seen = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (m_valid) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL notimeout_valid: got %0d valid cycles expected 0", seen); end
    end
    pulse_flush();
    wait_valid(20, got);
    checks++; if (!got) begin failures++; $display("FAIL notimeout_flush_timeout: got no m_valid expected m_valid"); end
    checks++; if (m_data !== 32'h0000005A || m_keep !== 4'h1) begin failures++; $display("FAIL notimeout_data: got %h/%h expected 0000005a/1", m_data, m_keep); end
    @(negedge clk);
`endif
  endtask

  task automatic test_monitors();
    checks++; if (viol_empty !== 0) begin failures++; $display("FAIL rd_en_while_empty: got %0d expected 0", viol_empty); end
    checks++; if (viol_hold !== 0) begin failures++; $display("FAIL rd_en_while_valid: got %0d expected 0", viol_hold); end
  endtask

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_flush_inflight();
    test_reset_midword();
    test_timeout();
    test_monitors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
